// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: one-instruction-per-clock issue controller for an 8-bit ALU.
// Define CYCLE_CNT_EN to add the saturating RUN-cycle counter on cyc_cnt.
module alu_issue_ctrl #(
  parameter int unsigned     PC_W     = 10,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            done,
  output logic [PC_W-1:0] imem_addr,
  input  logic [8:0]      imem_data,
  output logic [1:0]      tgt_idx,
  input  logic [PC_W-1:0] tgt_addr,
  output logic [3:0]      alu_op,
  output logic [2:0]      alu_imm,
  output logic [7:0]      alu_dat_a,
  output logic [7:0]      alu_dat_b,
  input  logic [7:0]      alu_rslt,
  input  logic            alu_zero,
  input  logic            alu_jen,
  input  logic            alu_brc_j
`ifdef CYCLE_CNT_EN
  ,
  output logic [15:0]     cyc_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      rf_q [8];
  logic [7:0]      rf_d [8];
  logic            zflag_q, zflag_d;
  logic            done_q, done_d;
`ifdef CYCLE_CNT_EN
  logic [15:0]     cyc_q, cyc_d;
`endif

  logic [3:0]      op;
  logic [2:0]      rb;
  logic            dbit;
  logic            run;
  logic            is_alu, is_brc, is_mov;
  logic            is_imm, is_jmp, is_nop, is_halt;
  logic            wr_en;
  logic [2:0]      wr_idx;
  logic [PC_W-1:0] pc_inc, pc_nxt;

  always_comb begin
    op      = imem_data[8:5];
    rb      = imem_data[2:0];
    dbit    = imem_data[4];
    run     = (state_q == S_RUN);
    pc_inc  = pc_q + PC_W'(1);
    is_alu  = (op <= 4'b0101);
    is_brc  = (op[3:1] == 3'b011);
    is_mov  = (op == 4'b1000);
    is_imm  = (op == 4'b1001) || (op[3:1] == 3'b101);
    is_jmp  = (op[3:1] == 3'b110);
    is_nop  = (op == 4'b1110);
    is_halt = (op == 4'b1111);
  end

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = 3'd0;
    pc_nxt = pc_inc;
    unique case (1'b1)
      is_alu, is_imm: wr_en = 1'b1;
      is_mov: begin
        wr_en  = 1'b1;
        wr_idx = dbit ? rb : 3'd0;
      end
      is_brc:  pc_nxt = alu_brc_j ? pc_inc : tgt_addr;
      is_jmp:  pc_nxt = alu_jen ? tgt_addr : pc_inc;
      is_halt: pc_nxt = pc_q;
      is_nop:  pc_nxt = pc_inc;
      default: pc_nxt = pc_inc;
    endcase
  end

  // Outside RUN the ALU sees xor of zeros so its carry clears.
  always_comb begin
    imem_addr = pc_q;
    tgt_idx   = imem_data[4:3];
    done      = done_q;
    alu_op    = 4'b0000;
    alu_imm   = 3'd0;
    alu_dat_a = 8'd0;
    alu_dat_b = 8'd0;
    if (run) begin
      alu_op    = op;
      alu_imm   = rb;
      alu_dat_a = (is_mov && !dbit) ? rf_q[rb] : rf_q[0];
      alu_dat_b = rf_q[rb];
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rf_d    = rf_q;
    zflag_d = zflag_q;
`ifdef CYCLE_CNT_EN
    cyc_d   = cyc_q;
`endif
    unique case (state_q)
      S_RUN: begin
        pc_d = pc_nxt;
        if (wr_en) begin
          rf_d[wr_idx] = alu_rslt;
          zflag_d      = alu_zero;
        end
        if (is_halt) state_d = S_DONE;
`ifdef CYCLE_CNT_EN
        if (cyc_q != 16'hFFFF) cyc_d = cyc_q + 16'd1;
`endif
      end
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = START_PC;
`ifdef CYCLE_CNT_EN
          cyc_d   = 16'd0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      rf_q    <= '{default: 8'd0};
      zflag_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef CYCLE_CNT_EN
      cyc_q   <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rf_q    <= rf_d;
      zflag_q <= zflag_d;
      done_q  <= done_d;
`ifdef CYCLE_CNT_EN
      cyc_q   <= cyc_d;
`endif
    end
  end

`ifdef CYCLE_CNT_EN
  assign cyc_cnt = cyc_q;
`endif

endmodule
